traffic_sensor_conditioner: RTL and testbench

Upstream front end for the four-approach `StopLight` controller. Synchronises and debounces the raw vehicle-detector inputs. Latches each approach's demand until the controller serves it with a green. Drives the controller's `*_traffic` request inputs and flags any approach that has waited too long.

---
 rtl/traffic_pkg.sv | 27 ++
 rtl/lane_conditioner.sv | 85 ++++++++
 rtl/traffic_sensor_conditioner.sv | 60 ++++++
 tb/tb_traffic_sensor_conditioner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_pkg : shared light codes and lane indices for the signal set |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam int NUM_LANES  = 4;
    localparam int LANE_NS    = 0;
    localparam int LANE_EW    = 1;
    localparam int LANE_SW_NE = 2;
    localparam int LANE_WN_ES = 3;

    localparam int DCNT_W = 16;
    localparam int WCNT_W = 17;

    // Only the exact one-hot green code grants service; anything else waits.
    function automatic logic is_green(input logic [2:0] light);
        return light == LIGHT_GREEN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lane_conditioner : sync, debounce, demand latch and wait timer       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lane_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned MAX_WAIT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_i,
    input  logic [2:0] light_i,
    output logic       traffic_o,
    output logic       starved_o
);

    localparam logic [DCNT_W-1:0] DB_LAST  = DCNT_W'(DEBOUNCE - 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);

    logic [1:0]        sync_q;
    logic              filt_q;
    logic              filt_d;
    logic [DCNT_W-1:0] dcnt_q;
    logic [DCNT_W-1:0] dcnt_d;
    logic              req_q;
    logic              req_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] wcnt_d;
    logic              starved_q;
    logic              starved_d;
    logic              green;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            filt_q    <= 1'b0;
            dcnt_q    <= '0;
            req_q     <= 1'b0;
            wcnt_q    <= '0;
            starved_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], sensor_i};
            filt_q    <= filt_d;
            dcnt_q    <= dcnt_d;
            req_q     <= req_d;
            wcnt_q    <= wcnt_d;
            starved_q <= starved_d;
        end
    end

    always_comb begin
        green  = is_green(light_i);
        filt_d = filt_q;
        dcnt_d = '0;
        if (sync_q[1] != filt_q) begin
            if (dcnt_q == DB_LAST) begin
                filt_d = ~filt_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end

        // Service clears take priority so a lingering car re-requests later.
        req_d = req_q;
        if (green) begin
            req_d = 1'b0;
        end else if (filt_q) begin
            req_d = 1'b1;
        end

        wcnt_d = '0;
        if (req_q && !green) begin
            wcnt_d = (wcnt_q == WAIT_MAX) ? wcnt_q : wcnt_q + 1'b1;
        end
        starved_d = (wcnt_d == WAIT_MAX);
    end

    assign traffic_o = req_q;
    assign starved_o = starved_q;

endmodule
`default_nettype wire

// File: rtl/traffic_sensor_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_sensor_conditioner : four-lane detector front end            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned MAX_WAIT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ns_sensor,
    input  logic                 ew_sensor,
    input  logic                 sw_ne_sensor,
    input  logic                 wn_es_sensor,
    input  logic [2:0]           ns_light,
    input  logic [2:0]           ew_light,
    input  logic [2:0]           sw_ne_light,
    input  logic [2:0]           wn_es_light,
    output logic                 ns_traffic,
    output logic                 ew_traffic,
    output logic                 sw_ne_traffic,
    output logic                 wn_es_traffic,
    output logic [NUM_LANES-1:0] starved
);

    logic [NUM_LANES-1:0] sensor_w;
    logic [NUM_LANES-1:0] traffic_w;
    logic [2:0]           light_w [NUM_LANES];

    assign sensor_w = {wn_es_sensor, sw_ne_sensor, ew_sensor, ns_sensor};

    assign light_w[LANE_NS]    = ns_light;
    assign light_w[LANE_EW]    = ew_light;
    assign light_w[LANE_SW_NE] = sw_ne_light;
    assign light_w[LANE_WN_ES] = wn_es_light;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_conditioner #(
            .DEBOUNCE (DEBOUNCE),
            .MAX_WAIT (MAX_WAIT)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .sensor_i  (sensor_w[i]),
            .light_i   (light_w[i]),
            .traffic_o (traffic_w[i]),
            .starved_o (starved[i])
        );
    end

    assign ns_traffic    = traffic_w[LANE_NS];
    assign ew_traffic    = traffic_w[LANE_EW];
    assign sw_ne_traffic = traffic_w[LANE_SW_NE];
    assign wn_es_traffic = traffic_w[LANE_WN_ES];

endmodule
`default_nettype wire

// File: tb/tb_traffic_sensor_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_traffic_sensor_conditioner : scoreboard bench for the front end   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_traffic_sensor_conditioner;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       ns_sensor, ew_sensor, sw_ne_sensor, wn_es_sensor;
    logic [2:0] ns_light, ew_light, sw_ne_light, wn_es_light;
    logic       ns_traffic, ew_traffic, sw_ne_traffic, wn_es_traffic;
    logic [3:0] starved;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         done = 1'b0;

    // Expected output vector {starved, wn_es, sw_ne, ew, ns} keyed by edge count
    int         q_cyc[$];
    logic [7:0] q_val[$];

    traffic_sensor_conditioner #(
        .DEBOUNCE (4),
        .MAX_WAIT (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ns_sensor     (ns_sensor),
        .ew_sensor     (ew_sensor),
        .sw_ne_sensor  (sw_ne_sensor),
        .wn_es_sensor  (wn_es_sensor),
        .ns_light      (ns_light),
        .ew_light      (ew_light),
        .sw_ne_light   (sw_ne_light),
        .wn_es_light   (wn_es_light),
        .ns_traffic    (ns_traffic),
        .ew_traffic    (ew_traffic),
        .sw_ne_traffic (sw_ne_traffic),
        .wn_es_traffic (wn_es_traffic),
        .starved       (starved)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int c, input logic [7:0] v);
        q_cyc.push_back(c);
        q_val.push_back(v);
    endtask

    initial begin : stimulus
        int t;
        rst          = 1'b1;
        ns_sensor    = 1'b1;
        ew_sensor    = 1'b1;
        sw_ne_sensor = 1'b1;
        wn_es_sensor = 1'b1;
        ns_light     = LIGHT_RED;
        ew_light     = LIGHT_RED;
        sw_ne_light  = LIGHT_RED;
        wn_es_light  = LIGHT_RED;
        push_exp(1, 8'h00);

        // Reset release with ns held high, then ns starvation and service
        @(negedge clk);
        rst          = 1'b0;
        ew_sensor    = 1'b0;
        sw_ne_sensor = 1'b0;
        wn_es_sensor = 1'b0;
        t = cyc;
        push_exp(t + 6,  8'h00);
        push_exp(t + 7,  8'h01);
        push_exp(t + 26, 8'h01);
        push_exp(t + 27, 8'h11);
        push_exp(t + 34, 8'h11);
        go(34);
        ns_light  = LIGHT_GREEN;
        ns_sensor = 1'b0;
        push_exp(t + 35, 8'h00);
        go(7);
        ns_light = LIGHT_RED;
        push_exp(t + 44, 8'h00);
        go(4);

        // ew: 3-sample glitch rejected, 4-sample pulse accepted
        t = cyc;
        ew_sensor = 1'b1;
        go(3);
        ew_sensor = 1'b0;
        push_exp(t + 12, 8'h00);
        go(12);
        t = cyc;
        ew_sensor = 1'b1;
        push_exp(t + 6, 8'h00);
        push_exp(t + 7, 8'h02);
        go(4);
        ew_sensor = 1'b0;
        go(6);
        ew_light = LIGHT_GREEN;
        push_exp(t + 11, 8'h00);
        go(6);
        ew_light = LIGHT_RED;
        push_exp(t + 20, 8'h00);
        go(5);

        // sw_ne: green clears immediately, re-request once red returns
        t = cyc;
        sw_ne_sensor = 1'b1;
        push_exp(t + 7,  8'h04);
        push_exp(t + 10, 8'h00);
        push_exp(t + 15, 8'h04);
        push_exp(t + 17, 8'h00);
        go(9);
        sw_ne_light = LIGHT_GREEN;
        go(5);
        sw_ne_light = LIGHT_RED;
        go(2);
        sw_ne_sensor = 1'b0;
        sw_ne_light  = LIGHT_GREEN;
        go(8);
        sw_ne_light = LIGHT_RED;
        push_exp(t + 28, 8'h00);
        go(5);

        // wn_es: demand stays latched after the car leaves
        t = cyc;
        wn_es_sensor = 1'b1;
        push_exp(t + 7,  8'h08);
        push_exp(t + 18, 8'h08);
        push_exp(t + 20, 8'h00);
        go(10);
        wn_es_sensor = 1'b0;
        go(9);
        wn_es_light = LIGHT_GREEN;
        go(3);
        wn_es_light = LIGHT_RED;
        push_exp(t + 26, 8'h00);
        go(5);

        // ns: asynchronous reset pulse mid-wait, then full restart
        t = cyc;
        ns_sensor = 1'b1;
        push_exp(t + 7, 8'h01);
        go(22);
        push_exp(t + 23, 8'h00);
        push_exp(t + 28, 8'h00);
        push_exp(t + 29, 8'h01);
        push_exp(t + 48, 8'h01);
        push_exp(t + 49, 8'h11);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        go(29);
        ns_light  = LIGHT_GREEN;
        ns_sensor = 1'b0;
        push_exp(t + 52, 8'h00);
        go(8);
        ns_light = LIGHT_RED;
        push_exp(t + 63, 8'h00);
        go(6);
        done = 1'b1;
    end

    initial begin : monitor
        logic [7:0] cur;
        logic [7:0] prev;
        bit         hit;
        prev = 8'h00;
        forever begin
            @(negedge clk);
            cur = {starved, wn_es_traffic, sw_ne_traffic, ew_traffic, ns_traffic};
            hit = 1'b0;
            while (q_cyc.size() > 0 && q_cyc[0] < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_check cyc=%0d got=none expected=%02h", q_cyc[0], q_val[0]);
                void'(q_cyc.pop_front());
                void'(q_val.pop_front());
            end
            if (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
                hit = 1'b1;
                checks++;
                if (cur !== q_val[0]) begin
                    failures++;
                    $display("FAIL out_vec cyc=%0d got=%02h expected=%02h", cyc, cur, q_val[0]);
                end
                void'(q_cyc.pop_front());
                void'(q_val.pop_front());
            end
            if (!hit && cur !== prev) begin
                checks++;
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%02h expected=%02h", cyc, cur, prev);
            end
            prev = cur;
            if (done) begin
                while (q_cyc.size() > 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unchecked cyc=%0d got=none expected=%02h", q_cyc[0], q_val[0]);
                    void'(q_cyc.pop_front());
                    void'(q_val.pop_front());
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
